out_port_arbiter: RTL and testbench

- Per-output-port scheduler of the switch. Shares one serial 1-byte output port (port_out / port_ready / port_read) between NUM_SRC input-side packet sources.
- Arbitration is round-robin at packet granularity. The grant is held from the first byte to src_last.
- Presents bytes through a one-entry output holding register at up to one byte per cycle, and counts forwarded packets.

---
 rtl/out_port_arbiter.sv | 105 ++++++++++
 tb/tb_out_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_arbiter.sv
// Round-robin, packet-granular scheduler sharing one byte-wide output port
// between NUM_SRC sources through a one-entry output holding register.
module out_port_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 8,
  parameter int CNT_W   = 16,
  localparam int GW     = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*DW-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_last,
  output logic [NUM_SRC-1:0]    src_ack,
  output logic [DW-1:0]         port_out,
  output logic                  port_ready,
  input  logic                  port_read,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      pkt_count
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    r_last_grant;
  logic [DW-1:0]    r_port_out;
  logic             r_port_ready;
  logic [CNT_W-1:0] r_pkt_count;

  logic             w_can_load;
  logic             w_ack;
  logic             w_req_found;
  logic [GW-1:0]    w_req_sel;
  logic [GW-1:0]    w_scan_idx;
  logic [DW-1:0]    w_lane_data [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
      assign w_lane_data[gi] = src_data[gi*DW +: DW];
      assign src_ack[gi]     = w_ack && (r_grant == GW'(gi));
    end
  endgenerate

  assign w_can_load = !r_port_ready || port_read;
  assign w_ack      = (r_state == XFER) && src_valid[r_grant] && w_can_load;

  // Scan starts one past the last packet's owner so every source gets a turn.
  always_comb begin
    w_req_found = 1'b0;
    w_req_sel   = r_last_grant;
    w_scan_idx  = r_last_grant;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_scan_idx = (w_scan_idx == GW'(NUM_SRC - 1)) ? '0 : w_scan_idx + GW'(1);
      if (!w_req_found && src_valid[w_scan_idx]) begin
        w_req_found = 1'b1;
        w_req_sel   = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_req_found) w_state_next = XFER;
      XFER:    if (w_ack && src_last[r_grant]) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_SRC - 1);
      r_port_out   <= '0;
      r_port_ready <= 1'b0;
      r_pkt_count  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_req_found)
        r_grant <= w_req_sel;
      // A load may coincide with a pop, keeping one byte per cycle.
      if (w_ack) begin
        r_port_out   <= w_lane_data[r_grant];
        r_port_ready <= 1'b1;
      end else if (r_port_ready && port_read) begin
        r_port_ready <= 1'b0;
      end
      if (w_ack && src_last[r_grant]) begin
        r_last_grant <= r_grant;
        r_pkt_count  <= r_pkt_count + CNT_W'(1);
      end
    end
  end

  assign port_out   = r_port_out;
  assign port_ready = r_port_ready;
  assign grant_id   = r_grant;
  assign busy       = (r_state == XFER);
  assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Scoreboard bench for out_port_arbiter: per-source packet queues drive the
// lanes, expected output bytes are queued in the order they must appear.
module tb_out_port_arbiter;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int CW = 4;  // narrow counter so the wrap is reachable quickly

  logic             clk;
  logic             rst_n;
  logic [NS-1:0]    src_valid;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_last;
  logic [NS-1:0]    src_ack;
  logic [DW-1:0]    port_out;
  logic             port_ready;
  logic             port_read;
  logic [1:0]       grant_id;
  logic             busy;
  logic [CW-1:0]    pkt_count;

  out_port_arbiter #(.NUM_SRC(NS), .DW(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ack(src_ack), .port_out(port_out),
    .port_ready(port_ready), .port_read(port_read), .grant_id(grant_id),
    .busy(busy), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]    srcq [NS][$];
  logic [7:0]    sb [$];
  logic [NS-1:0] gap;
  int            n_err;
  int            n_checks;
  int            bubbles;
  bit            started;

  logic [NS-1:0] s_ack;
  logic          s_ready;
  logic [7:0]    s_out;
  logic          s_busy;
  logic [1:0]    s_grant;
  logic [CW-1:0] s_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      src_valid[i]         = (srcq[i].size() > 0) && !gap[i];
      src_data[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0][7:0] : 8'h00;
      src_last[i]          = (srcq[i].size() > 0) ? srcq[i][0][8] : 1'b0;
    end
  endtask

  task automatic load_pkt(input int lane, input int first, input int inc, input int n);
    for (int j = 0; j < n; j++) begin
      logic [7:0] b;
      b = 8'(first + j * inc);
      srcq[lane].push_back({(j == n - 1), b});
      sb.push_back(b);
    end
    drive();
  endtask

  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    s_ack = src_ack; s_ready = port_ready; s_out = port_out;
    s_busy = busy; s_grant = grant_id; s_cnt = pkt_count;
    if (rst_n) begin
      check("ack_onehot0", 32'($onehot0(s_ack)), 32'd1);
      if (s_ready && port_read) begin
        if (sb.size() == 0) begin
          check("sb_extra_byte", 32'(s_out), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          $display("xfer byte=0x%02h exp=0x%02h grant=%0d cnt=%0d", s_out, e, s_grant, s_cnt);
          check("byte", 32'(s_out), 32'(e));
        end
        started = 1'b1;
      end else if (!s_ready && started && sb.size() > 0) begin
        bubbles++;
      end
    end
    @(posedge clk);
    #1;
    if (rst_n)
      for (int i = 0; i < NS; i++)
        if (s_ack[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask

  function automatic bit srcs_pending();
    for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int bound);
    int c;
    c = 0;
    while ((sb.size() > 0 || srcs_pending() || s_busy) && c < bound) begin
      tick();
      c++;
    end
    check("drain_in_time", 32'(c < bound), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    sb.delete();
    gap = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    started = 1'b0;
    bubbles = 0;
    s_busy = 1'b0;
  endtask

  initial begin
    int c;
    n_err = 0; n_checks = 0; bubbles = 0; started = 1'b0;
    gap = '0; port_read = 1'b1; rst_n = 1'b0; s_busy = 1'b0;
    drive();
    do_reset();
    check("rst_ready", 32'(port_ready), 0);
    check("rst_out", 32'(port_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_count", 32'(pkt_count), 0);
    check("rst_ack", 32'(src_ack), 0);

    // Single 3-byte packet: latency and per-cycle timing.
    load_pkt(0, 'hA1, 1, 3);
    tick(); check("t1_c0_ack", 32'(s_ack), 0);   check("t1_c0_busy", 32'(s_busy), 0);
    tick(); check("t1_c1_ack", 32'(s_ack), 1);   check("t1_c1_ready", 32'(s_ready), 0);
    check("t1_c1_busy", 32'(s_busy), 1);
    tick(); check("t1_c2_ready", 32'(s_ready), 1); check("t1_c2_ack", 32'(s_ack), 1);
    tick(); check("t1_c3_ack", 32'(s_ack), 1);
    tick(); check("t1_c4_ack", 32'(s_ack), 0);   check("t1_c4_busy", 32'(s_busy), 0);
    check("t1_c4_ready", 32'(s_ready), 1);
    check("t1_grant", 32'(s_grant), 0);        check("t1_count", 32'(s_cnt), 1);
    drain(20);

    // All four sources, two bytes each: round-robin order and bubbles.
    do_reset();
    for (int i = 0; i < NS; i++) load_pkt(i, 'h10 + i, 'h10, 2);
    drain(60);
    check("t2_bubbles", 32'(bubbles), 3);
    check("t2_count", 32'(s_cnt), 4);
    check("t2_grant", 32'(s_grant), 3);

    // Sources 0 and 3 after 3 was last: 0 first, then 3.
    load_pkt(0, 'h30, 0, 1);
    load_pkt(3, 'h33, 0, 1);
    drain(30);
    check("t3_count", 32'(s_cnt), 6);
    check("t3_grant", 32'(s_grant), 3);

    // Backpressure: consumer stalls with the first byte held.
    port_read = 1'b0;
    load_pkt(1, 'h40, 1, 4);
    c = 0;
    do begin tick(); c++; end while (!s_ready && c < 10);
    check("t4_first_seen", 32'(s_ready), 1);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_out", 32'(s_out), 'h40);
      check("t4_hold_ack", 32'(s_ack[1]), 0);
      if (k < 4) tick();
    end
    port_read = 1'b1;
    drain(30);
    check("t4_count", 32'(s_cnt), 7);

    // Gap: source 2 pauses mid-packet while source 0 waits.
    load_pkt(2, 'h50, 1, 5);
    load_pkt(0, 'h60, 1, 2);
    c = 0;
    while (srcq[2].size() > 3 && c < 20) begin tick(); c++; end
    check("t5_two_taken", 32'(srcq[2].size()), 3);
    gap[2] = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_gap_grant", 32'(s_grant), 2);
      check("t5_gap_ack0", 32'(s_ack[0]), 0);
    end
    gap[2] = 1'b0;
    drive();
    drain(40);
    check("t5_count", 32'(s_cnt), 9);

    // Reset in the middle of a 5-byte packet.
    load_pkt(1, 'h70, 1, 5);
    c = 0;
    while (srcq[1].size() > 3 && c < 20) begin tick(); c++; end
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < NS; i++) srcq[i].delete();
    sb.delete();
    drive();
    tick();
    check("t6_ready", 32'(s_ready), 0);
    check("t6_busy", 32'(s_busy), 0);
    check("t6_count", 32'(s_cnt), 0);
    rst_n = 1'b1;
    started = 1'b0;
    load_pkt(0, 'h80, 0, 1);
    load_pkt(3, 'h83, 0, 1);
    drain(30);
    check("t6_count2", 32'(s_cnt), 2);

    // Counter wrap with single-byte packets.
    do_reset();
    for (int k = 0; k < 15; k++) load_pkt(k % NS, 'h90 + k, 0, 1);
    drain(100);
    check("t7_count15", 32'(s_cnt), 15);
    load_pkt(3, 'h9F, 0, 1);
    drain(20);
    check("t7_wrap", 32'(s_cnt), 0);
    check("t7_sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
